serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_fa.sv | 14 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// full_adder_cell: combinational one-bit full adder.
// Ports: a, b, ci in; s (sum bit), cry (carry out) out.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic cry
);

  assign s   = a ^ b ^ ci;
  assign cry = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock.
// Ports: clk, rst_n (sync, active low), start, a_in, b_in,
//   ci_in in; busy, done, sum, cout out; ovf out when
//   SERIAL_ADDER_OVF_EN is defined (two's-complement overflow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cry;
  logic             last;
  logic             accept;

  full_adder_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .ci  (carry),
    .s   (fa_s),
    .cry (fa_cry)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && start;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      s_sr  <= '0;
      carry <= ci_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
      carry <= fa_cry;
      cnt   <= cnt + 1'b1;
      // Publish only on the final step so sum never
      // shows a partially shifted value.
      if (last) begin
        sum  <= {fa_s, s_sr[WIDTH-1:1]};
        cout <= fa_cry;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into the MSB here
        ovf  <= carry ^ fa_cry;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Random and directed adds against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ci_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .ci_in (ci_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Plain arithmetic reference model.
  task automatic model(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic ci);
    int unsigned t;
    int sa, sb, ss;
    t = int'(a) + int'(b) + int'(ci);
    exp_sum  = W'(t);
    exp_cout = t >= (1 << W);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    ss = sa + sb + int'(ci);
    exp_ovf = (ss > (1 << (W - 1)) - 1) ||
              (ss < -(1 << (W - 1)));
  endtask

  // One add; optional stray start at sample ic (RUN).
  task automatic do_add(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci,
                        input int ic,
                        input logic [W-1:0] a2,
                        input logic [W-1:0] b2);
    logic [W-1:0] old_sum;
    logic         old_cout;
    int nb, nd, dk;
    old_sum  = exp_sum;
    old_cout = exp_cout;
    model(a, b, ci);
    nb = 0; nd = 0; dk = 0;
    @(negedge clk);
    a_in = a; b_in = b; ci_in = ci; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        nd++;
        if (dk == 0) dk = k;
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, exp_ovf);
`endif
      end else if (dk == 0) begin
        chk("sum_hold", sum, old_sum);
        chk("cout_hold", cout, old_cout);
      end
      start = (k == ic);
      a_in  = (k == ic) ? a2 : W'($urandom);
      b_in  = (k == ic) ? b2 : W'($urandom);
      ci_in = 1'($urandom);
      if (dk != 0 && k >= dk + 2) break;
    end
    start = 1'b0;
    if (dk == 0) chk("done_timeout", 0, 1);
    chk("busy_cycles", nb, W);
    chk("done_latency", dk, W + 1);
    chk("done_count", nd, 1);
  endtask

  initial begin
    int dks[$];
    int nd;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    do_add(8'h0F, 8'h01, 1'b0, 0, '0, '0);
    do_add(8'hFF, 8'h01, 1'b0, 0, '0, '0);
    do_add(8'h7F, 8'h01, 1'b0, 0, '0, '0);
    do_add(8'hFF, 8'hFF, 1'b1, 3, 8'h12, 8'h34);
    chk("dir_ff_ff", sum, 8'hFF);

    // Reset in the middle of a run.
    @(negedge clk);
    a_in = 8'h55; b_in = 8'hAA; ci_in = 0; start = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_sum", sum, 0);
    chk("rr_cout", cout, 0);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rr_no_done", nd, 0);
    exp_sum = '0; exp_cout = 1'b0;
    do_add(8'h03, 8'h04, 1'b0, 0, '0, '0);
    chk("after_rst", sum, 8'h07);

    // start held high: back-to-back adds.
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h01; ci_in = 0; start = 1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (done) begin
        dks.push_back(k);
        chk("b2b_sum", sum, 8'h02);
      end
    end
    start = 1'b0;
    chk("b2b_count", dks.size(), 3);
    if (dks.size() == 3) begin
      chk("b2b_first", dks[0], W + 1);
      chk("b2b_gap1", dks[1] - dks[0], 10);
      chk("b2b_gap2", dks[2] - dks[1], 10);
    end
    repeat (12) @(negedge clk);
    exp_sum = 8'h02; exp_cout = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_add(ra, rb, 1'($urandom),
             (i % 3 == 0) ? int'($urandom_range(1, W)) : 0,
             W'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
